// File: rtl/dmem_bytelane_sync.sv
// ============================================================================
// Module : dmem_bytelane_sync
// Brief  : RV32I data memory: byte lanes, sub-word extension, 1-cycle read,
//          misalignment flag, optional clear sequencer (DMEM_CLEAR_ON_RESET_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dmem_bytelane_sync #(
  parameter int    DEPTH     = 512,
  parameter int    IDX_W     = 9,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] w_data,
  input  logic        w_en,
  input  logic        r_en,
  input  logic [1:0]  mem_size,
  input  logic        load_unsigned,
  input  logic        peripheral_sel,
  output logic [31:0] r_data,
  output logic        r_valid,
  output logic        misaligned,
  output logic        busy
);

  logic [31:0]      mem_q [DEPTH];
  logic [IDX_W-1:0] idx;
  logic [1:0]       off;
  logic             accept, legal, store_we, load_go;
  logic [3:0]       lane_be;
  logic [31:0]      lane_wdata, rd_word, rd_shift, rd_ext;
  logic [31:0]      r_data_q, r_data_d;
  logic             r_valid_q, misaligned_q;
  logic             unused_addr_hi;

  assign idx            = data_addr[IDX_W+1:2];
  assign off            = data_addr[1:0];
  assign unused_addr_hi = ^data_addr[31:IDX_W+2];

`ifdef DMEM_CLEAR_ON_RESET_EN
  typedef enum logic [0:0] {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;
  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             clr_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) state_d = S_READY;
      end
      default: ;
    endcase
  end

  assign busy = (state_q == S_CLEAR);
`else
  assign busy = 1'b0;
`endif

  // Reserved size (3) and unaligned half/word are rejected outright.
  always_comb begin
    case (mem_size)
      2'd0:    legal = 1'b1;
      2'd1:    legal = ~off[0];
      2'd2:    legal = (off == 2'd0);
      default: legal = 1'b0;
    endcase
  end

  assign accept   = (w_en | r_en) & ~busy & ~peripheral_sel & ~rst;
  assign store_we = accept & w_en & legal;
  assign load_go  = accept & r_en & legal;

  always_comb begin
    lane_be    = 4'b0000;
    lane_wdata = w_data;
    case (mem_size)
      2'd0: begin
        lane_be    = 4'b0001 << off;
        lane_wdata = {4{w_data[7:0]}};
      end
      2'd1: begin
        lane_be    = off[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{w_data[15:0]}};
      end
      2'd2:    lane_be = 4'b1111;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
    if (clr_we) begin
      mem_q[cnt_q] <= '0;
    end else
`endif
    if (store_we) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_be[b]) mem_q[idx][8*b +: 8] <= lane_wdata[8*b +: 8];
      end
    end
  end

  // Array read sees pre-store contents, giving read-before-write on same-cycle SW/LW.
  assign rd_word  = mem_q[idx];
  assign rd_shift = rd_word >> {off, 3'b000};

  always_comb begin
    case (mem_size)
      2'd0:    rd_ext = {{24{~load_unsigned & rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    rd_ext = {{16{~load_unsigned & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_word;
    endcase
  end

  assign r_data_d = load_go ? rd_ext : r_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_q     <= '0;
      r_valid_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      r_data_q     <= r_data_d;
      r_valid_q    <= load_go;
      misaligned_q <= accept & ~legal;
    end
  end

  assign r_data     = r_data_q;
  assign r_valid    = r_valid_q;
  assign misaligned = misaligned_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_bytelane_sync.sv
// ============================================================================
// Module : tb_dmem_bytelane_sync
// Brief  : Randomized + directed self-checking bench against a byte-array model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_bytelane_sync;

  localparam int DEPTH = 512;
  localparam int NBYTE = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_addr, w_data;
  logic        w_en, r_en, load_unsigned, peripheral_sel;
  logic [1:0]  mem_size;
  logic [31:0] r_data;
  logic        r_valid, misaligned, busy;

  logic [7:0]  model [NBYTE];
  logic [31:0] exp_rd;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  dmem_bytelane_sync #(.DEPTH(DEPTH), .IDX_W(9), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .data_addr(data_addr), .w_data(w_data),
    .w_en(w_en), .r_en(r_en), .mem_size(mem_size), .load_unsigned(load_unsigned),
    .peripheral_sel(peripheral_sel), .r_data(r_data), .r_valid(r_valid),
    .misaligned(misaligned), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One request per cycle: drive at negedge, clock it in, compare at next negedge.
  task automatic op(input logic we, input logic re, input logic [1:0] sz,
                    input logic lu, input logic ps, input logic [31:0] addr,
                    input logic [31:0] wd);
    logic        acc, legal, exp_v, exp_m;
    int          base, n;
    logic [31:0] v;
    w_en = we; r_en = re; mem_size = sz; load_unsigned = lu;
    peripheral_sel = ps; data_addr = addr; w_data = wd;
    acc   = (we | re) & ~ps;
    legal = (sz == 2'd0) || (sz == 2'd1 && addr[0] == 1'b0) ||
            (sz == 2'd2 && addr[1:0] == 2'd0);
    exp_v = acc & re & legal;
    exp_m = acc & ~legal;
    base  = int'(addr % NBYTE);
    n     = 1 << sz;
    if (exp_v) begin
      v = 0;
      for (int i = 0; i < n; i++) v = v | (32'(model[base+i]) << (8*i));
      if (!lu && sz == 2'd0 && v[7])  v = v | 32'hFFFFFF00;
      if (!lu && sz == 2'd1 && v[15]) v = v | 32'hFFFF0000;
      exp_rd = v;
    end
    if (acc && we && legal)
      for (int i = 0; i < n; i++) model[base+i] = wd[8*i +: 8];
    @(posedge clk);
    @(negedge clk);
    check("r_valid", r_valid, exp_v);
    check("misaligned", misaligned, exp_m);
    check("r_data", r_data, exp_rd);
    check("busy", busy, 1'b0);
  endtask

  task automatic idle();
    op(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset(input logic load_inflight);
    int n;
    rst = 1'b1; r_en = load_inflight; w_en = 1'b0; data_addr = 32'h0;
    mem_size = 2'd2; peripheral_sel = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; r_en = 1'b0;
    check("rst_r_valid", r_valid, 1'b0);
    check("rst_misaligned", misaligned, 1'b0);
    check("rst_r_data", r_data, 32'h0);
    exp_rd = 32'h0;
`ifdef DMEM_CLEAR_ON_RESET_EN
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      w_en = 1'b1; r_en = 1'b1; mem_size = 2'd2;
      data_addr = $urandom; w_data = $urandom;
      @(posedge clk);
      @(negedge clk);
      check("busy_r_valid", r_valid, 1'b0);
    end
    w_en = 1'b0; r_en = 1'b0;
    check("busy_len", n, DEPTH);
    for (int i = 0; i < NBYTE; i++) model[i] = 8'h00;
`else
    n = 0;
    check("busy_off", busy, 1'b0);
`endif
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; mem_size = 2'd2; load_unsigned = 1'b0;
    peripheral_sel = 1'b0; data_addr = 32'h0; w_data = 32'h0; exp_rd = 32'h0;
    for (int i = 0; i < NBYTE; i++) model[i] = 8'h00;
    repeat (2) @(negedge clk);
    do_reset(1'b0);

`ifdef DMEM_CLEAR_ON_RESET_EN
    op(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h7FC, 32'h0);
    check("t1_lw7fc", r_data, 32'h0);
    check("t1_valid", r_valid, 1'b1);
    // Restart during an active clear must recount the full depth.
    rst = 1'b1; @(posedge clk); @(negedge clk); rst = 1'b0;
    repeat (100) @(negedge clk);
    do_reset(1'b0);
`endif

    for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'(i*4), $urandom);

    // Byte-lane merging
    op(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h10, 32'h11223344);
    op(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h11, 32'h000000AA);
    op(1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 32'h12, 32'h0000BEEF);
    op(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h10, 32'h0);
    check("t2_lw10", r_data, 32'hBEEFAA44);

    // Sign/zero extension
    op(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h20, 32'h0080FF7F);
    op(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 32'h21, 32'h0);
    check("t3_lb21s", r_data, 32'hFFFFFFFF);
    op(1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 32'h21, 32'h0);
    check("t3_lb21u", r_data, 32'h000000FF);
    op(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 32'h22, 32'h0);
    check("t3_lh22s", r_data, 32'h00000080);
    op(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 32'h20, 32'h0);
    check("t3_lb20s", r_data, 32'h0000007F);

    // Misaligned / reserved
    op(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 32'h23, 32'h0);
    check("t4_lh23", misaligned, 1'b1);
    op(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h22, 32'hCAFEF00D);
    op(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 32'h20, 32'h12345678);
    op(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h20, 32'h0);
    check("t4_lw20", r_data, 32'h0080FF7F);

    // Peripheral gating and read-before-write
    op(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h40, 32'h01020304);
    op(1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    op(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h40, 32'h0);
    check("t5_lw40", r_data, 32'h01020304);
    op(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h44, 32'h55667788);
    op(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 32'h44, 32'h99AABBCC);
    check("t5_rbw_old", r_data, 32'h55667788);
    op(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h44, 32'h0);
    check("t5_rbw_new", r_data, 32'h99AABBCC);

    // Randomized traffic, full address width exercises index aliasing
    for (int k = 0; k < 600; k++)
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
         1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), $urandom, $urandom);
    op(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 32'h0000_0800, 32'hA5A5_5A5A);
    op(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0);
    check("alias_800", r_data, 32'hA5A5_5A5A);

    // Back-to-back loads, then reset with a load request pending
    op(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0);
    op(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h4, 32'h0);
    op(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h8, 32'h0);
    do_reset(1'b1);
    op(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
